// File: rtl/serial_mac.sv
// serial_mac: bit-serial shift-add multiply-accumulate unit.
//
// The multiplier is consumed LSB first, one bit per clock, so a product takes WIDTH cycles in
// BUSY regardless of operand values. Results are presented in DONE until downstream accepts.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   ACC_WIDTH  accumulator width in bits (>= 2*WIDTH)
//   SIGNED     0: unsigned operands, 1: two's-complement operands
//
// Ports
//   i_clk      clock, rising edge
//   i_arstn    asynchronous active-low reset
//   i_valid    operand pair valid
//   o_ready    unit can accept operands (IDLE only)
//   i_a        multiplicand
//   i_b        multiplier, consumed LSB first
//   i_acc      1: add product to accumulator, 0: accumulator := product
//   o_valid    result valid (DONE only)
//   i_ready    downstream accepts result
//   o_product  product of the last accepted pair
//   o_acc      accumulator, wraps silently modulo 2^ACC_WIDTH
module serial_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_arstn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH-1:0]       i_a,
  input  logic [WIDTH-1:0]       i_b,
  input  logic                   i_acc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [2*WIDTH-1:0]     o_product,
  output logic [ACC_WIDTH-1:0]   o_acc
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 acc_flag_q, acc_flag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        partial_q, partial_d;
  logic [PW-1:0]        product_q, product_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        addend;
  logic [PW-1:0]        step_sum;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic                 last_bit;

  // Datapath for one shift-add step on bit cnt_q of the multiplier.
  always_comb begin
    a_ext    = {{WIDTH{SIGNED & a_q[WIDTH-1]}}, a_q};
    addend   = a_ext << cnt_q;
    last_bit = (cnt_q == CW'(WIDTH - 1));
    step_sum = partial_q;
    if (b_q[cnt_q]) begin
      // In two's complement the multiplier MSB carries weight -2^(WIDTH-1).
      if (SIGNED && last_bit) begin
        step_sum = partial_q - addend;
      end else begin
        step_sum = partial_q + addend;
      end
    end
    prod_ext = '0;
    prod_ext[PW-1:0] = step_sum;
    for (int i = PW; i < ACC_WIDTH; i++) begin
      prod_ext[i] = SIGNED & step_sum[PW-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_flag_d = acc_flag_q;
    cnt_d      = cnt_q;
    partial_d  = partial_q;
    product_d  = product_q;
    acc_d      = acc_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          a_d        = i_a;
          b_d        = i_b;
          acc_flag_d = i_acc;
          cnt_d      = '0;
          partial_d  = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        partial_d = step_sum;
        cnt_d     = cnt_q + CW'(1);
        if (last_bit) begin
          product_d = step_sum;
          acc_d     = (acc_flag_q ? acc_q : '0) + prod_ext;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      acc_flag_q <= 1'b0;
      cnt_q      <= '0;
      partial_q  <= '0;
      product_q  <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_flag_q <= acc_flag_d;
      cnt_q      <= cnt_d;
      partial_q  <= partial_d;
      product_q  <= product_d;
      acc_q      <= acc_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_product = product_q;
  assign o_acc     = acc_q;

endmodule

// File: tb/tb_serial_mac.sv
// Self-checking bench for serial_mac. Three instances share one stimulus stream:
// unsigned with a 20-bit accumulator, signed with a 20-bit accumulator, and unsigned with a
// 16-bit accumulator (exercises wrap). Expected values come from plain integer arithmetic.
module tb_serial_mac;

  logic       clk;
  logic       arstn;
  logic       valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc;
  logic       ready;

  logic        rdy_u, vld_u, rdy_s, vld_s, rdy_w, vld_w;
  logic [15:0] prod_u, prod_s, prod_w;
  logic [19:0] acc_u, acc_s;
  logic [15:0] acc_w;

  // Reference accumulators and products.
  logic [19:0] m_acc_u, m_acc_s;
  logic [15:0] m_acc_w;
  logic [15:0] m_prod_u, m_prod_s;

  int n_checks = 0;
  int n_pass   = 0;

  serial_mac #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b0)) u_uns (
    .i_clk(clk), .i_arstn(arstn), .i_valid(valid), .o_ready(rdy_u), .i_a(a), .i_b(b),
    .i_acc(acc), .o_valid(vld_u), .i_ready(ready), .o_product(prod_u), .o_acc(acc_u)
  );

  serial_mac #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1)) u_sgn (
    .i_clk(clk), .i_arstn(arstn), .i_valid(valid), .o_ready(rdy_s), .i_a(a), .i_b(b),
    .i_acc(acc), .o_valid(vld_s), .i_ready(ready), .o_product(prod_s), .o_acc(acc_s)
  );

  serial_mac #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b0)) u_w16 (
    .i_clk(clk), .i_arstn(arstn), .i_valid(valid), .o_ready(rdy_w), .i_a(a), .i_b(b),
    .i_acc(acc), .o_valid(vld_w), .i_ready(ready), .o_product(prod_w), .o_acc(acc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc_u  = '0;
    m_acc_s  = '0;
    m_acc_w  = '0;
    m_prod_u = '0;
    m_prod_s = '0;
  endtask

  function automatic int to_signed8(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic model_op(input logic [7:0] ma, input logic [7:0] mb, input logic flag);
    int unsigned pu;
    int          ps;
    pu       = int'(ma) * int'(mb);
    ps       = to_signed8(ma) * to_signed8(mb);
    m_prod_u = 16'(pu);
    m_prod_s = 16'(ps);
    m_acc_u  = 20'((flag ? int'(m_acc_u) : 0) + int'(pu));
    m_acc_w  = 16'((flag ? int'(m_acc_w) : 0) + int'(pu));
    m_acc_s  = 20'((flag ? int'(m_acc_s) : 0) + ps);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_prod_u"}, 32'(prod_u), 32'(m_prod_u));
    check({tag, "_acc_u"},  32'(acc_u),  32'(m_acc_u));
    check({tag, "_prod_s"}, 32'(prod_s), 32'(m_prod_s));
    check({tag, "_acc_s"},  32'(acc_s),  32'(m_acc_s));
    check({tag, "_prod_w"}, 32'(prod_w), 32'(m_prod_u));
    check({tag, "_acc_w"},  32'(acc_w),  32'(m_acc_w));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy_u && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(rdy_u), 32'd1);
  endtask

  // One full transaction; hold = number of DONE cycles with i_ready low and i_valid high.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oflag,
                       input int hold);
    wait_ready();
    valid = 1'b1;
    a     = oa;
    b     = ob;
    acc   = oflag;
    ready = (hold == 0);
    @(posedge clk);
    model_op(oa, ob, oflag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        valid = (hold != 0);
        a     = 8'($urandom);
        b     = 8'($urandom);
        acc   = 1'($urandom);
      end
      check("busy_valid", 32'({vld_u, vld_s, vld_w}), 32'd0);
      check("busy_ready", 32'({rdy_u, rdy_s, rdy_w}), 32'd0);
    end
    @(negedge clk);
    check("done_valid", 32'({vld_u, vld_s, vld_w}), 32'd7);
    check_results("done");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'({vld_u, vld_s, vld_w}), 32'd7);
      check("hold_ready", 32'({rdy_u, rdy_s, rdy_w}), 32'd0);
      check_results("hold");
    end
    ready = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'({vld_u, vld_s, vld_w}), 32'd0);
    check("idle_ready", 32'({rdy_u, rdy_s, rdy_w}), 32'd7);
  endtask

  initial begin
    arstn = 1'b0;
    valid = 1'b0;
    a     = '0;
    b     = '0;
    acc   = 1'b0;
    ready = 1'b1;
    model_reset();
    #1;
    check("rst_ready", 32'({rdy_u, rdy_s, rdy_w}), 32'd7);
    check("rst_valid", 32'({vld_u, vld_s, vld_w}), 32'd0);
    check_results("rst");
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(8'hFF, 8'hFF, 1'b0, 0);
    check("t1_prod", 32'(prod_u), 32'h0000_FE01);
    check("t1_acc",  32'(acc_u),  32'd65025);
    do_op(8'd3, 8'd4, 1'b0, 0);
    check("t2_acc12", 32'(acc_u), 32'd12);
    do_op(8'd5, 8'd6, 1'b1, 0);
    check("t2_acc42", 32'(acc_u), 32'd42);
    do_op(8'd2, 8'd2, 1'b0, 0);
    check("t2_acc4", 32'(acc_u), 32'd4);
    do_op(8'h80, 8'h80, 1'b0, 0);
    check("t3_min_sq", 32'(prod_s), 32'h0000_4000);
    do_op(8'hFF, 8'h7F, 1'b0, 0);
    check("t3_prod", 32'(prod_s), 32'h0000_FF81);
    check("t3_acc",  32'(acc_s),  32'h000F_FF81);
    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b0, 5);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    check("t6_wrap", 32'(acc_w), 32'h0000_FC02);

    // Reset in the third BUSY cycle aborts the operation.
    wait_ready();
    valid = 1'b1;
    a     = 8'h5A;
    b     = 8'hC3;
    acc   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    model_reset();
    check("abort_ready", 32'({rdy_u, rdy_s, rdy_w}), 32'd7);
    check("abort_valid", 32'({vld_u, vld_s, vld_w}), 32'd0);
    check_results("abort");
    @(negedge clk);
    arstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'({vld_u, vld_s, vld_w}), 32'd0);
    end
    check("abort_ready_after", 32'({rdy_u, rdy_s, rdy_w}), 32'd7);

    // First operation after reset with i_acc=1 accumulates onto zero.
    do_op(8'hB7, 8'h9E, 1'b1, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
